shift_word_rx: RTL and testbench
================================

# shift_word_rx

Serial-to-parallel receiver for the bit stream produced by the shift-register serializer path. Samples one bit per qualified clock, frames words using a start-of-word strobe, assembles WIDTH-bit words in either bit order, and presents each completed word on a valid/ready output with a single-entry output register. Sits between the serial link and any parallel consumer (FIFO, register file, display logic).

## Interface

- WIDTH, 4, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1 = first received bit lands in pdata_o[WIDTH-1]; 0 = first bit lands in pdata_o[0]

- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset, sampled on rising clk
- sdata_i  input  1  serial data bit
- svalid_i  input  1  sdata_i is valid this cycle; bits are sampled only when high
- sframe_i  input  1  qualified by svalid_i; marks the current bit as bit 0 of a new word
- pdata_o  output  WIDTH  assembled word
- pvalid_o  output  1  pdata_o holds an unconsumed word
- pready_i  input  1  consumer accepts pdata_o when pvalid_o && pready_i
- overrun_o  output  1  one-cycle pulse: completed word dropped because output register was full
- frame_err_o  output  1  one-cycle pulse: sframe_i arrived mid-word; partial word discarded
- busy_o  output  1  high while a word is partially assembled (state SHIFT)

## Operation

- States: IDLE, SHIFT.
- IDLE: bits with svalid_i=1, sframe_i=0 are ignored. svalid_i=1, sframe_i=1 → load bit into shifter, bitcnt=1, go to SHIFT.
- SHIFT: each svalid_i=1, sframe_i=0 cycle shifts in one bit, bitcnt+1. svalid_i=0 cycles are stalls; state and count hold indefinitely.
- Shift direction: MSB_FIRST=1 → shifter = {shifter[WIDTH-2:0], sdata_i}; MSB_FIRST=0 → shifter = {sdata_i, shifter[WIDTH-1:1]}. After WIDTH bits the first bit sits in MSB (resp. LSB).
- Word completion: the cycle the WIDTH-th bit is sampled. Completed word = shifter contents including that bit. Go to IDLE.
- Output register is "free" when pvalid_o=0 or pready_i=1 in the completion cycle. Free → load pdata_o, pvalid_o=1 next cycle. Not free → drop word, pulse overrun_o next cycle; pdata_o/pvalid_o unchanged.
- Mid-word frame: sframe_i=1 with svalid_i=1 in SHIFT → discard partial word, pulse frame_err_o next cycle, treat bit as bit 0 of a new word (bitcnt=1, stay SHIFT). Never an overrun.
- Completion cycle with sframe_i=1 is not possible for WIDTH≥2 except as a mid-word frame; frame wins, no word emitted.
- bitcnt width: clog2(WIDTH+1); never exceeds WIDTH.
- Handshake: pvalid_o, once set, stays high with pdata_o stable until a cycle with pready_i=1. Simultaneous accept and new completion in the same cycle → new word loaded, pvalid_o stays 1, no overrun.
- sframe_i with svalid_i=0 is ignored.

## Timing

- Reset (rst=1 at rising clk): state=IDLE, bitcnt=0, shifter=0, pdata_o=0, pvalid_o=0, overrun_o=0, frame_err_o=0, busy_o=0. Reset mid-word discards the partial word and any held output word.
- Latency: last bit sampled at edge N → pvalid_o=1 and pdata_o valid after edge N (visible in cycle N+1).
- overrun_o and frame_err_o: high exactly one cycle, registered, in the cycle after the causing edge.
- Throughput: back-to-back words with no idle cycles (frame on the cycle after a completion) sustained at one bit per clock when pready_i is held high.
- busy_o is registered; equals (state==SHIFT).

## Test plan

- WIDTH=4, MSB_FIRST=1, pready_i=1: bits 1,1,0,1 (frame on first), consecutive cycles → pdata_o=4'b1101, pvalid_o=1 one cycle after 4th bit, then 0.
- MSB_FIRST=0, same stream 1,1,0,1 → pdata_o=4'b1011; stalls (svalid_i=0 for 3 cycles between bits 2 and 3) give identical result, busy_o held high during stalls.
- pready_i=0: receive 4'b1101, then 4'b0110 → pdata_o stays 4'b1101, overrun_o pulses once; raise pready_i → pvalid_o drops next cycle.
- Frame after 2 bits (1,0), then new word 0,0,1,1 → frame_err_o one pulse, pdata_o=4'b0011, no overrun.
- Back-to-back words 4'b1101, 4'b0010 with pready_i=1 and no gaps → two valid words on consecutive 4-cycle boundaries; accept+complete same cycle causes no overrun.
- Assert rst after 3 bits of a word with a held output word → all outputs 0 next cycle; next framed 4'b1111 received correctly.

Source files
------------

// File: rtl/shift_word_rx_if.sv
// Bus bundle for shift_word_rx: serial input side plus the valid/ready parallel output.
interface shift_word_rx_if #(
   parameter int unsigned WIDTH = 4
);
   logic             sdata_i;
   logic             svalid_i;
   logic             sframe_i;
   logic             pready_i;
   logic [WIDTH-1:0] pdata_o;
   logic             pvalid_o;
   logic             overrun_o;
   logic             frame_err_o;
   logic             busy_o;

   modport master (
      output sdata_i, svalid_i, sframe_i, pready_i,
      input  pdata_o, pvalid_o, overrun_o, frame_err_o, busy_o
   );

   modport slave (
      input  sdata_i, svalid_i, sframe_i, pready_i,
      output pdata_o, pvalid_o, overrun_o, frame_err_o, busy_o
   );
endinterface

// File: rtl/shift_word_rx.sv
// Serial-to-parallel receiver: frames words on sframe_i, assembles WIDTH bits in
// either order, and holds each finished word in a single-entry valid/ready register.
module shift_word_rx #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic           clk,
   input logic           rst,
   shift_word_rx_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shifter_q, shifter_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;
   logic             pvalid_q, pvalid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             out_free;
   logic [WIDTH-1:0] word_next;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      if (MSB_FIRST) return {cur[WIDTH-2:0], b};
      else           return {b, cur[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shifter_q   <= '0;
         pdata_q     <= '0;
         pvalid_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shifter_q   <= shifter_d;
         pdata_q     <= pdata_d;
         pvalid_q    <= pvalid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shifter_d   = shifter_q;
      pdata_d     = pdata_q;
      pvalid_d    = pvalid_q;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      out_free    = !pvalid_q || bus.pready_i;
      word_next   = shift_in(shifter_q, bus.sdata_i);

      if (pvalid_q && bus.pready_i) pvalid_d = 1'b0;

      if (bus.svalid_i) begin
         unique case (state_q)
            IDLE: begin
               if (bus.sframe_i) begin
                  shifter_d = shift_in('0, bus.sdata_i);
                  bitcnt_d  = CW'(1);
                  state_d   = SHIFT;
               end
            end
            SHIFT: begin
               if (bus.sframe_i) begin
                  // A frame strobe mid-word restarts assembly with this bit as bit 0.
                  frame_err_d = 1'b1;
                  shifter_d   = shift_in('0, bus.sdata_i);
                  bitcnt_d    = CW'(1);
               end else if (bitcnt_q == CW'(WIDTH - 1)) begin
                  shifter_d = word_next;
                  bitcnt_d  = '0;
                  state_d   = IDLE;
                  if (out_free) begin
                     pdata_d  = word_next;
                     pvalid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  shifter_d = word_next;
                  bitcnt_d  = bitcnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.pdata_o     = pdata_q;
   assign bus.pvalid_o    = pvalid_q;
   assign bus.overrun_o   = overrun_q;
   assign bus.frame_err_o = frame_err_q;
   assign bus.busy_o      = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_word_rx.sv
// Bench for shift_word_rx: an MSB-first and an LSB-first instance share stimulus and
// are checked against a bit-queue reference model, a vector table and corner sequences.
module tb_shift_word_rx;

   localparam int unsigned W = 4;

   logic tb_clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   shift_word_rx_if #(.WIDTH(W)) ifm ();
   shift_word_rx_if #(.WIDTH(W)) ifl ();

   shift_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(tb_clk), .rst(rst), .bus(ifm.slave));
   shift_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(tb_clk), .rst(rst), .bus(ifl.slave));

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // Reference model: bits of the word in progress, in arrival order.
   logic   bits_q[$];
   logic   m_pvalid, m_ovr, m_ferr;
   logic [W-1:0] m_pm, m_pl;

   typedef struct {
      logic r, sd, sv, sf, pr;
      logic e_pv;
      logic [W-1:0] e_pm, e_pl;
      logic e_ov, e_fe, e_bz;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic sd, input logic sv, input logic sf, input logic pr);
      logic free;
      if (r) begin
         bits_q.delete();
         m_pvalid = 1'b0; m_pm = '0; m_pl = '0; m_ovr = 1'b0; m_ferr = 1'b0;
         return;
      end
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      free   = !m_pvalid || pr;
      if (m_pvalid && pr) m_pvalid = 1'b0;
      if (sv) begin
         if (sf) begin
            if (bits_q.size() != 0) m_ferr = 1'b1;
            bits_q.delete();
            bits_q.push_back(sd);
         end else if (bits_q.size() != 0) begin
            bits_q.push_back(sd);
            if (bits_q.size() == W) begin
               if (free) begin
                  for (int i = 0; i < W; i++) begin
                     m_pm[W-1-i] = bits_q[i];
                     m_pl[i]     = bits_q[i];
                  end
                  m_pvalid = 1'b1;
               end else begin
                  m_ovr = 1'b1;
               end
               bits_q.delete();
            end
         end
      end
   endtask

   task automatic compare_model();
      logic bz;
      bz = (bits_q.size() != 0);
      check("pvalid_msb", 32'(ifm.pvalid_o), 32'(m_pvalid));
      check("pvalid_lsb", 32'(ifl.pvalid_o), 32'(m_pvalid));
      check("pdata_msb", 32'(ifm.pdata_o), 32'(m_pm));
      check("pdata_lsb", 32'(ifl.pdata_o), 32'(m_pl));
      check("overrun_msb", 32'(ifm.overrun_o), 32'(m_ovr));
      check("overrun_lsb", 32'(ifl.overrun_o), 32'(m_ovr));
      check("frame_err_msb", 32'(ifm.frame_err_o), 32'(m_ferr));
      check("frame_err_lsb", 32'(ifl.frame_err_o), 32'(m_ferr));
      check("busy_msb", 32'(ifm.busy_o), 32'(bz));
      check("busy_lsb", 32'(ifl.busy_o), 32'(bz));
   endtask

   // Drive one cycle of inputs, advance one edge, update the model, sample on the falling edge.
   task automatic step(input logic r, input logic sd, input logic sv, input logic sf, input logic pr);
      rst = r;
      ifm.sdata_i = sd; ifm.svalid_i = sv; ifm.sframe_i = sf; ifm.pready_i = pr;
      ifl.sdata_i = sd; ifl.svalid_i = sv; ifl.sframe_i = sf; ifl.pready_i = pr;
      @(posedge tb_clk);
      model_update(r, sd, sv, sf, pr);
      @(negedge tb_clk);
      compare_model();
   endtask

   task automatic add(input logic r, input logic sd, input logic sv, input logic sf, input logic pr,
                      input logic pv, input logic [W-1:0] pm, input logic [W-1:0] pl,
                      input logic ov, input logic fe, input logic bz);
      vec_t v;
      v.r = r; v.sd = sd; v.sv = sv; v.sf = sf; v.pr = pr;
      v.e_pv = pv; v.e_pm = pm; v.e_pl = pl; v.e_ov = ov; v.e_fe = fe; v.e_bz = bz;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b1;
      ifm.sdata_i = 0; ifm.svalid_i = 0; ifm.sframe_i = 0; ifm.pready_i = 0;
      ifl.sdata_i = 0; ifl.svalid_i = 0; ifl.sframe_i = 0; ifl.pready_i = 0;
      m_pvalid = 0; m_pm = '0; m_pl = '0; m_ovr = 0; m_ferr = 0;
      @(negedge tb_clk);

      //   r  sd sv sf pr | pv  pm     pl     ov fe bz
      add(1, 0, 0, 0, 1,   0, 4'h0, 4'h0, 0, 0, 0);
      add(0, 1, 1, 1, 1,   0, 4'h0, 4'h0, 0, 0, 1);
      add(0, 1, 1, 0, 1,   0, 4'h0, 4'h0, 0, 0, 1);
      add(0, 0, 1, 0, 1,   0, 4'h0, 4'h0, 0, 0, 1);
      add(0, 1, 1, 0, 1,   1, 4'hD, 4'hB, 0, 0, 0);
      add(0, 0, 0, 0, 1,   0, 4'hD, 4'hB, 0, 0, 0);
      add(0, 1, 1, 1, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 1, 1, 0, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 1, 0, 1, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 0, 0, 1, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 1, 0, 0, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 0, 1, 0, 1,   0, 4'hD, 4'hB, 0, 0, 1);
      add(0, 1, 1, 0, 0,   1, 4'hD, 4'hB, 0, 0, 0);
      add(0, 0, 0, 0, 0,   1, 4'hD, 4'hB, 0, 0, 0);
      add(0, 0, 0, 0, 1,   0, 4'hD, 4'hB, 0, 0, 0);
      add(0, 1, 1, 0, 1,   0, 4'hD, 4'hB, 0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].sd, tbl[i].sv, tbl[i].sf, tbl[i].pr);
         check($sformatf("tbl%0d_pvalid", i), 32'(ifm.pvalid_o), 32'(tbl[i].e_pv));
         check($sformatf("tbl%0d_pdata_msb", i), 32'(ifm.pdata_o), 32'(tbl[i].e_pm));
         check($sformatf("tbl%0d_pdata_lsb", i), 32'(ifl.pdata_o), 32'(tbl[i].e_pl));
         check($sformatf("tbl%0d_overrun", i), 32'(ifm.overrun_o), 32'(tbl[i].e_ov));
         check($sformatf("tbl%0d_frame_err", i), 32'(ifm.frame_err_o), 32'(tbl[i].e_fe));
         check($sformatf("tbl%0d_busy", i), 32'(ifl.busy_o), 32'(tbl[i].e_bz));
      end

      // Overrun: second word arrives while the first is still held.
      step(0, 1, 1, 1, 0); step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0); step(0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0);
      check("ovr_pulse", 32'(ifm.overrun_o), 32'd1);
      check("ovr_hold_data", 32'(ifm.pdata_o), 32'hD);
      step(0, 0, 0, 0, 0);
      check("ovr_single_pulse", 32'(ifm.overrun_o), 32'd0);
      check("ovr_still_valid", 32'(ifm.pvalid_o), 32'd1);
      step(0, 0, 0, 0, 1);
      check("ovr_accept_drop", 32'(ifm.pvalid_o), 32'd0);

      // Mid-word frame after two bits, then a clean word 0,0,1,1.
      step(0, 1, 1, 1, 1); step(0, 0, 1, 0, 1);
      step(0, 0, 1, 1, 1);
      check("ferr_pulse", 32'(ifm.frame_err_o), 32'd1);
      check("ferr_busy", 32'(ifm.busy_o), 32'd1);
      step(0, 0, 1, 0, 1);
      check("ferr_single_pulse", 32'(ifm.frame_err_o), 32'd0);
      step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1);
      check("ferr_word_msb", 32'(ifm.pdata_o), 32'h3);
      check("ferr_word_lsb", 32'(ifl.pdata_o), 32'hC);
      check("ferr_no_ovr", 32'(ifm.overrun_o), 32'd0);
      step(0, 0, 0, 0, 1);

      // Back-to-back words; second completes in the same cycle the first is accepted.
      step(0, 1, 1, 1, 1); step(0, 1, 1, 0, 1); step(0, 0, 1, 0, 1); step(0, 1, 1, 0, 1);
      check("b2b_first", 32'(ifm.pdata_o), 32'hD);
      step(0, 0, 1, 1, 0); step(0, 0, 1, 0, 0); step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 1);
      check("b2b_second_msb", 32'(ifm.pdata_o), 32'h2);
      check("b2b_second_lsb", 32'(ifl.pdata_o), 32'h4);
      check("b2b_valid", 32'(ifm.pvalid_o), 32'd1);
      check("b2b_no_ovr", 32'(ifm.overrun_o), 32'd0);

      // Reset mid-word with a word still held.
      step(0, 1, 1, 1, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      check("rst_pvalid", 32'(ifm.pvalid_o), 32'd0);
      check("rst_pdata", 32'(ifm.pdata_o), 32'd0);
      check("rst_busy", 32'(ifm.busy_o), 32'd0);
      step(0, 1, 1, 1, 1); step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1); step(0, 1, 1, 0, 1);
      check("post_rst_word_msb", 32'(ifm.pdata_o), 32'hF);
      check("post_rst_word_lsb", 32'(ifl.pdata_o), 32'hF);
      check("post_rst_valid", 32'(ifl.pvalid_o), 32'd1);

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 2),
              1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
